// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache.
// Loads that hit are answered in the same cycle. A read miss refills the
// whole 4-word line from memory. Every store is sent to memory, and the
// cached copy is updated only when the line is already resident.
//
// Memory handshake: the cache holds mem_read or mem_write at 1, together
// with a stable mem_addr/mem_wdata, until the one-cycle mem_ack arrives.
// The beat completes on the clock edge that samples mem_ack=1. mem_read and
// mem_write are never both 1. The CPU side treats cpu_stall=1 as
// "not ready": it must hold its request unchanged until cpu_stall=0.
module dcache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbg_state
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_cnt;
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES][4];

    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic                  w_is_store;
    logic                  w_is_load;
    logic                  w_start_fill;
    logic                  w_fill_beat;
    logic                  w_fill_last;
    logic                  w_store_hit;
    logic                  w_unused_addr_lsbs;

    // Byte-lane bits are not used: the cache works on whole words.
    assign w_unused_addr_lsbs = ^cpu_addr[1:0];

    assign w_offset   = cpu_addr[3:2];
    assign w_index    = cpu_addr[INDEX_BITS+3:4];
    assign w_tag      = cpu_addr[31:INDEX_BITS+4];
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // A simultaneous read and write request counts as a store.
    assign w_is_store = cpu_write;
    assign w_is_load  = cpu_read && !cpu_write;
    assign dbg_state  = r_state;

    // Next-state, handshake outputs and array write strobes.
    always_comb begin
        w_next_state = r_state;
        cpu_rdata    = 32'd0;
        cpu_stall    = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        w_start_fill = 1'b0;
        w_fill_beat  = 1'b0;
        w_fill_last  = 1'b0;
        w_store_hit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_store) begin
                    cpu_stall    = 1'b1;
                    w_next_state = ST_WRITE;
                end else if (w_is_load) begin
                    if (w_hit) begin
                        cpu_rdata = r_data[w_index][w_offset];
                    end else begin
                        cpu_stall    = 1'b1;
                        w_start_fill = 1'b1;
                        w_next_state = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                // The final ack still stalls; the retried load hits next cycle.
                cpu_stall = 1'b1;
                mem_read  = 1'b1;
                mem_addr  = {cpu_addr[31:4], r_cnt, 2'b00};
                if (mem_ack) begin
                    w_fill_beat = 1'b1;
                    if (r_cnt == 2'd3) begin
                        w_fill_last  = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                mem_write = 1'b1;
                mem_addr  = {cpu_addr[31:2], 2'b00};
                mem_wdata = cpu_wdata;
                cpu_stall = !mem_ack;
                if (mem_ack) begin
                    w_store_hit  = w_hit;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, beat counter and valid bits; reset aborts any refill or store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_valid <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_fill) begin
                r_cnt            <= 2'd0;
                r_valid[w_index] <= 1'b0;
            end else if (w_fill_beat) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_fill_last) begin
                r_valid[w_index] <= 1'b1;
            end
        end
    end

    // Data and tag arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (w_fill_beat) begin
            r_data[w_index][r_cnt] <= mem_rdata;
        end
        if (w_store_hit) begin
            r_data[w_index][w_offset] <= cpu_wdata;
        end
        if (w_fill_last) begin
            r_tag[w_index] <= w_tag;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed bench for dcache with a bench-side word memory that
// acknowledges each request after a programmable number of cycles.
module tb_dcache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    int ack_lat    = 1;
    int wait_cnt   = 0;
    bit inject_ack = 1'b0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] wr_cyc_addr[$];
    logic [31:0] exp_q[$];

    dcache #(.INDEX_BITS(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Untouched memory words read back as 0xC0DE0000 | address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'hC0DE_0000 | a;
    endfunction

    // Memory responder: ack after ack_lat request cycles, log every beat.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!reset || !(mem_read || mem_write)) begin
            wait_cnt = 0;
        end else begin
            wait_cnt++;
            if (wait_cnt >= ack_lat) begin
                wait_cnt = 0;
                mem_ack  = 1'b1;
                if (mem_read) begin
                    mem_rdata = mem_word(mem_addr);
                    rd_log.push_back(mem_addr);
                end else begin
                    mem_model[mem_addr] = mem_wdata;
                    wr_data_log.push_back(mem_wdata);
                end
            end
        end
        if (inject_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_exp_line(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Load driver: holds the request until stall drops; returns cycle count.
    task automatic do_read(input logic [31:0] a, output int cycles,
                           output logic [31:0] data, output bit overlap);
        @(posedge clk); #1;
        rd_log.delete();
        cpu_addr = a; cpu_read = 1'b1; cpu_write = 1'b0;
        cycles = 0; data = 32'd0; overlap = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            cycles++;
            if (mem_read && mem_write) overlap = 1'b1;
            if (!cpu_stall) begin
                data = cpu_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_read = 1'b0;
    endtask

    // Store driver: optional cpu_read alongside; records mem_addr per write cycle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both,
                            output int cycles, output bit rd_seen);
        @(posedge clk); #1;
        wr_cyc_addr.delete();
        wr_data_log.delete();
        cpu_addr = a; cpu_wdata = d; cpu_read = both; cpu_write = 1'b1;
        cycles = 0; rd_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            cycles++;
            if (mem_read) rd_seen = 1'b1;
            if (mem_write) wr_cyc_addr.push_back(mem_addr);
            if (!cpu_stall) break;
        end
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_read = 1'b0; cpu_write = 1'b0;
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({mem_read, mem_write, cpu_stall} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {mem_read, mem_write, cpu_stall});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== 96'd0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h expected zeros", mem_addr, mem_wdata, cpu_rdata);
        end
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({mem_read, mem_write, cpu_stall} !== 3'b000) begin
            n_fail++; $display("FAIL idle_no_req: got %b expected 000", {mem_read, mem_write, cpu_stall});
        end
    endtask

    task automatic test_read_miss();
        int cyc; logic [31:0] dat; bit ovl;
        do_read(32'h100, cyc, dat, ovl);
        n_checks++;
        if (cyc !== 6) begin n_fail++; $display("FAIL miss_cycles: got %0d expected 6", cyc); end
        n_checks++;
        if (dat !== 32'hC0DE0100) begin n_fail++; $display("FAIL miss_data: got %h expected c0de0100", dat); end
        n_checks++;
        if (ovl !== 1'b0) begin n_fail++; $display("FAIL miss_rw_overlap: got %b expected 0", ovl); end
        set_exp_line(32'h100);
        n_checks++;
        if (rd_log.size() !== 4) begin n_fail++; $display("FAIL miss_beats: got %0d expected 4", rd_log.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= rd_log.size() || rd_log[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL miss_beat%0d_addr: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 32'h0, exp_q[i]);
            end
        end
        do_read(32'h104, cyc, dat, ovl);
        n_checks++;
        if (cyc !== 1) begin n_fail++; $display("FAIL hit104_cycles: got %0d expected 1", cyc); end
        n_checks++;
        if (dat !== 32'hC0DE0104) begin n_fail++; $display("FAIL hit104_data: got %h expected c0de0104", dat); end
    endtask

    task automatic test_hits();
        int cyc; logic [31:0] dat; bit ovl;
        do_read(32'h108, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat, 32'(rd_log.size())} !== {32'd1, 32'hC0DE0108, 32'd0}) begin
            n_fail++; $display("FAIL hit108: got cyc=%0d data=%h beats=%0d expected 1 c0de0108 0", cyc, dat, rd_log.size());
        end
        do_read(32'h10C, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat, 32'(rd_log.size())} !== {32'd1, 32'hC0DE010C, 32'd0}) begin
            n_fail++; $display("FAIL hit10c: got cyc=%0d data=%h beats=%0d expected 1 c0de010c 0", cyc, dat, rd_log.size());
        end
    endtask

    task automatic test_conflict();
        int cyc; logic [31:0] dat; bit ovl;
        do_read(32'h200, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat} !== {32'd6, 32'hC0DE0200}) begin
            n_fail++; $display("FAIL conflict200: got cyc=%0d data=%h expected 6 c0de0200", cyc, dat);
        end
        set_exp_line(32'h200);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= rd_log.size() || rd_log[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL conflict_beat%0d_addr: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 32'h0, exp_q[i]);
            end
        end
        do_read(32'h100, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat, 32'(rd_log.size())} !== {32'd6, 32'hC0DE0100, 32'd4}) begin
            n_fail++; $display("FAIL conflict_remiss100: got cyc=%0d data=%h beats=%0d expected 6 c0de0100 4", cyc, dat, rd_log.size());
        end
    endtask

    task automatic test_store();
        int cyc; logic [31:0] dat; bit ovl; bit rds;
        ack_lat = 3;
        do_write(32'h104, 32'hDEADBEEF, 1'b0, cyc, rds);
        ack_lat = 1;
        n_checks++;
        if (cyc !== 4) begin n_fail++; $display("FAIL store_cycles: got %0d expected 4", cyc); end
        n_checks++;
        if (wr_cyc_addr.size() !== 3) begin n_fail++; $display("FAIL store_wr_len: got %0d expected 3", wr_cyc_addr.size()); end
        foreach (wr_cyc_addr[i]) begin
            n_checks++;
            if (wr_cyc_addr[i] !== 32'h104) begin n_fail++; $display("FAIL store_addr%0d: got %h expected 00000104", i, wr_cyc_addr[i]); end
        end
        n_checks++;
        if (wr_data_log.size() !== 1 || wr_data_log[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL store_mem_data: got n=%0d %h expected 1 deadbeef", wr_data_log.size(), (wr_data_log.size() > 0) ? wr_data_log[0] : 32'h0);
        end
        n_checks++;
        if (rds !== 1'b0) begin n_fail++; $display("FAIL store_no_read: got %b expected 0", rds); end
        do_read(32'h104, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat} !== {32'd1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL store_hit_read: got cyc=%0d data=%h expected 1 deadbeef", cyc, dat);
        end
        do_write(32'h300, 32'h12345678, 1'b0, cyc, rds);
        n_checks++;
        if ({cyc, 32'(wr_cyc_addr.size())} !== {32'd2, 32'd1}) begin
            n_fail++; $display("FAIL store_miss: got cyc=%0d wr_cycles=%0d expected 2 1", cyc, wr_cyc_addr.size());
        end
        do_read(32'h300, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat, 32'(rd_log.size())} !== {32'd6, 32'h12345678, 32'd4}) begin
            n_fail++; $display("FAIL no_allocate_300: got cyc=%0d data=%h beats=%0d expected 6 12345678 4", cyc, dat, rd_log.size());
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc; logic [31:0] dat; bit ovl;
        @(posedge clk); #1;
        rd_log.delete();
        cpu_addr = 32'h100; cpu_read = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (rd_log.size() >= 2) break;
        end
        n_checks++;
        if (rd_log.size() !== 2) begin n_fail++; $display("FAIL midfill_acks: got %0d expected 2", rd_log.size()); end
        @(posedge clk); #1;
        n_checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h108}) begin
            n_fail++; $display("FAIL midfill_beat3: got rd=%b addr=%h expected 1 00000108", mem_read, mem_addr);
        end
        reset = 1'b0; cpu_read = 1'b0;
        #1;
        n_checks++;
        if ({mem_read, mem_write, cpu_stall, dbg_state} !== 5'b0) begin
            n_fail++; $display("FAIL midfill_reset_ctrl: got %b %b %b %0d expected all 0", mem_read, mem_write, cpu_stall, dbg_state);
        end
        n_checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== 96'd0) begin
            n_fail++; $display("FAIL midfill_reset_data: got %h %h %h expected zeros", mem_addr, mem_wdata, cpu_rdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_read(32'h100, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat, 32'(rd_log.size())} !== {32'd6, 32'hC0DE0100, 32'd4}) begin
            n_fail++; $display("FAIL after_reset_refill: got cyc=%0d data=%h beats=%0d expected 6 c0de0100 4", cyc, dat, rd_log.size());
        end
        n_checks++;
        if (rd_log.size() == 0 || rd_log[0] !== 32'h100) begin
            n_fail++; $display("FAIL after_reset_first_beat: got %h expected 00000100", (rd_log.size() > 0) ? rd_log[0] : 32'h0);
        end
    endtask

    task automatic test_read_write_both();
        int cyc; logic [31:0] dat; bit ovl; bit rds;
        do_write(32'h108, 32'hCAFEF00D, 1'b1, cyc, rds);
        n_checks++;
        if ({cyc, 32'(wr_cyc_addr.size()), 31'd0, rds} !== {32'd2, 32'd1, 32'd0}) begin
            n_fail++; $display("FAIL both_as_store: got cyc=%0d wr_cycles=%0d rd_seen=%b expected 2 1 0", cyc, wr_cyc_addr.size(), rds);
        end
        do_read(32'h108, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat} !== {32'd1, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL both_hit_update: got cyc=%0d data=%h expected 1 cafef00d", cyc, dat);
        end
        @(posedge clk); #1;
        inject_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        inject_ack = 1'b0;
        n_checks++;
        if ({dbg_state, mem_read, mem_write} !== 4'b0) begin
            n_fail++; $display("FAIL idle_ack_ignored: got state=%0d rd=%b wr=%b expected 0 0 0", dbg_state, mem_read, mem_write);
        end
        do_read(32'h10C, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat} !== {32'd1, 32'hC0DE010C}) begin
            n_fail++; $display("FAIL idle_ack_hit10c: got cyc=%0d data=%h expected 1 c0de010c", cyc, dat);
        end
        do_read(32'h400, cyc, dat, ovl);
        n_checks++;
        if ({cyc, dat} !== {32'd6, 32'hC0DE0400}) begin
            n_fail++; $display("FAIL idle_ack_fill400: got cyc=%0d data=%h expected 6 c0de0400", cyc, dat);
        end
        set_exp_line(32'h400);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= rd_log.size() || rd_log[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL fill400_beat%0d_addr: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 32'h0, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_hits();
        test_conflict();
        test_store();
        test_reset_mid_fill();
        test_read_write_both();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
